// File: rtl/syncd_filt_pkg.sv
// Shared constants and types for the syncd_filt input conditioner.
package syncd_filt_pkg;

   localparam int unsigned STAGES_MIN = 2;
   localparam int unsigned STAGES_MAX = 4;

   typedef enum logic [1:0] {
      ACT_SAME  = 2'd0,
      ACT_COUNT = 2'd1,
      ACT_TAKE  = 2'd2
   } filt_act_e;

endpackage

// File: rtl/syncd_filt_ch.sv
// One channel: synchroniser chain, optional stability filter, edge flop.
module syncd_filt_ch
   import syncd_filt_pkg::*;
#(
   parameter int   STAGES  = 2,
   parameter int   FILT    = 0,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;
   logic w_s;
   logic w_q;
   logic r_qd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= {STAGES{RST_VAL}};
      else          r_sync <= {r_sync[STAGES-2:0], d};
   end

   assign w_s = r_sync[STAGES-1];

   generate
      if (FILT == 0) begin : g_nofilt
         assign w_q = w_s;
      end else begin : g_filt
         localparam int CW = clog2(FILT + 1);
         logic [CW-1:0] r_cnt;
         logic          r_q;
         filt_act_e     w_act;

         // q only moves once s has disagreed for FILT consecutive cycles
         always_comb begin
            w_act = ACT_SAME;
            if (w_s != r_q)
               w_act = (r_cnt == CW'(FILT - 1)) ? ACT_TAKE : ACT_COUNT;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_q   <= RST_VAL;
               r_cnt <= '0;
            end else begin
               unique case (w_act)
                  ACT_SAME:  r_cnt <= '0;
                  ACT_COUNT: r_cnt <= r_cnt + CW'(1);
                  ACT_TAKE: begin
                     r_q   <= w_s;
                     r_cnt <= '0;
                  end
                  default:   r_cnt <= '0;
               endcase
            end
         end

         assign w_q = r_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_qd <= RST_VAL;
      else          r_qd <= w_q;
   end

   assign q    = w_q;
   assign rise = w_q & ~r_qd;
   assign fall = ~w_q & r_qd;

endmodule

// File: rtl/syncd_filt.sv
// Multi-channel async-input conditioner: sync, glitch filter, edge detect.
module syncd_filt
   import syncd_filt_pkg::*;
#(
   parameter int               WIDTH   = 1,
   parameter int               STAGES  = 2,
   parameter int               FILT    = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   generate
      if (STAGES < int'(STAGES_MIN) || STAGES > int'(STAGES_MAX)) begin : g_bad
         $error("syncd_filt: STAGES must be 2..4");
      end
   endgenerate

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_ch
         syncd_filt_ch #(
            .STAGES  (STAGES),
            .FILT    (FILT),
            .RST_VAL (RST_VAL[i])
         ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (d[i]),
            .q       (q[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
         );
      end
   endgenerate

   assign changed = |(rise | fall);

endmodule

// File: tb/tb_syncd_filt.sv
// Directed bench for syncd_filt: three parameterisations, table + sequences.
module tb_syncd_filt;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // A: WIDTH=1 STAGES=2 FILT=0
   logic       rst_a, d_a, q_a, ri_a, fa_a, ch_a;
   // B: WIDTH=4 STAGES=3 FILT=4
   logic       rst_b, ch_b;
   logic [3:0] d_b, q_b, ri_b, fa_b;
   // C: WIDTH=2 STAGES=2 FILT=2 RST_VAL=11
   logic       rst_c, ch_c;
   logic [1:0] d_c, q_c, ri_c, fa_c;

   syncd_filt #(.WIDTH(1), .STAGES(2), .FILT(0), .RST_VAL(1'b0)) u_a (
      .clk(clk), .reset_n(rst_a), .d(d_a),
      .q(q_a), .rise(ri_a), .fall(fa_a), .changed(ch_a)
   );

   syncd_filt #(.WIDTH(4), .STAGES(3), .FILT(4), .RST_VAL(4'b0000)) u_b (
      .clk(clk), .reset_n(rst_b), .d(d_b),
      .q(q_b), .rise(ri_b), .fall(fa_b), .changed(ch_b)
   );

   syncd_filt #(.WIDTH(2), .STAGES(2), .FILT(2), .RST_VAL(2'b11)) u_c (
      .clk(clk), .reset_n(rst_c), .d(d_c),
      .q(q_c), .rise(ri_c), .fall(fa_c), .changed(ch_c)
   );

   typedef struct {
      logic [3:0] d;
      logic [3:0] q;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       chg;
   } vec_t;

   vec_t tbl[28];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   initial begin
      int lat;
      int npulse;
      logic [3:0] tog;

      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      d_a = 1'b0; d_b = 4'b0000; d_c = 2'b11;
      repeat (3) tick();

      chk("rst_a", {q_a, ri_a, fa_a, ch_a}, 4'b0000);
      chk("rst_b", {q_b, ri_b, fa_b, ch_b}, 13'h0);
      chk("rst_c", {q_c, ri_c, fa_c, ch_c}, 7'b11_00_00_0);

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      repeat (2) tick();

      // Test 1: plain 2-flop sync, latency 2, single rise/fall
      d_a = 1'b1;
      tick(); chk("t1_e1", {q_a, ri_a, fa_a, ch_a}, 4'b0000);
      tick(); chk("t1_e2", {q_a, ri_a, fa_a, ch_a}, 4'b1101);
      tick(); chk("t1_e3", {q_a, ri_a, fa_a, ch_a}, 4'b1000);
      d_a = 1'b0;
      tick(); chk("t1_f1", {q_a, ri_a, fa_a, ch_a}, 4'b1000);
      tick(); chk("t1_f2", {q_a, ri_a, fa_a, ch_a}, 4'b0011);
      tick(); chk("t1_f3", {q_a, ri_a, fa_a, ch_a}, 4'b0000);

      // Test 5: RST_VAL=11 held through release, then one fall
      npulse = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if ({ri_c, fa_c, ch_c} != 5'b0 || q_c != 2'b11) npulse++;
      end
      chk("t5_idle", npulse, 0);
      d_c = 2'b00;
      lat = 0;
      npulse = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (ch_c) begin
            npulse++;
            if (lat == 0) lat = i;
            chk("t5_fall", {fa_c, ri_c}, 4'b1100);
         end
      end
      chk("t5_lat", lat, 4);
      chk("t5_npulse", npulse, 1);
      chk("t5_q", q_c, 2'b00);

      // Table for B (STAGES=3, FILT=4): short pulse, 4-cycle pulse, 0101 hold
      for (int r = 0; r < 28; r++) begin
         tbl[r].d    = (r < 3) ? 4'b0001 :
                       (r >= 8 && r < 12) ? 4'b0001 :
                       (r >= 20) ? 4'b0101 : 4'b0000;
         tbl[r].q    = 4'b0000;
         tbl[r].rise = 4'b0000;
         tbl[r].fall = 4'b0000;
         tbl[r].chg  = 1'b0;
      end
      for (int r = 14; r <= 17; r++) tbl[r].q = 4'b0001;
      tbl[14].rise = 4'b0001; tbl[14].chg = 1'b1;
      tbl[18].fall = 4'b0001; tbl[18].chg = 1'b1;
      tbl[26].q = 4'b0101; tbl[27].q = 4'b0101;
      tbl[26].rise = 4'b0101; tbl[26].chg = 1'b1;

      for (int r = 0; r < 28; r++) begin
         d_b = tbl[r].d;
         tick();
         chk($sformatf("tbl_r%0d", r), {q_b, ri_b, fa_b, ch_b},
             {tbl[r].q, tbl[r].rise, tbl[r].fall, tbl[r].chg});
      end

      // Test 4: toggling every 2 cycles never passes the filter
      npulse = 0;
      for (int i = 0; i < 50; i++) begin
         tog = (i % 4 < 2) ? 4'b1010 : 4'b0101;
         d_b = tog;
         tick();
         if (q_b != 4'b0101 || ri_b != 4'b0 || fa_b != 4'b0 || ch_b)
            npulse++;
      end
      chk("t4_bad_cycles", npulse, 0);
      d_b = 4'b0101;
      repeat (10) tick();
      chk("t4_settle", {q_b, ri_b, fa_b, ch_b}, {4'b0101, 9'b0});

      // Test 6: reset during a partial count, then full latency again
      d_b = 4'b1111;
      repeat (5) tick();
      chk("t6_pre", q_b, 4'b0101);
      rst_b = 1'b0;
      #1;
      chk("t6_rst", {q_b, ri_b, fa_b, ch_b}, 13'h0);
      repeat (2) tick();
      chk("t6_hold", {q_b, ri_b, fa_b, ch_b}, 13'h0);
      rst_b = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (q_b == 4'b1111) begin
            lat = i;
            chk("t6_rise", {ri_b, fa_b, ch_b}, 9'b1111_0000_1);
            break;
         end
      end
      chk("t6_lat", lat, 7);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
